// File: rtl/alu_arbiter.sv
// Two-requester arbiter/sequencer in front of one shared combinational 8-bit ALU.
// Define ALU_ARB_FIXED_PRI_EN for fixed priority (requester 0 wins); default is round-robin.
module alu_arbiter #(
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [2:0]    req0_op,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [2:0]    req1_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_op,
  input  logic [DW-1:0] alu_y,
  input  logic          alu_c,
  input  logic          alu_v,
  input  logic          alu_n,
  input  logic          alu_z,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_y,
  output logic [3:0]    rsp_flags
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          id_q, id_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]    op_q, op_d;
  logic [DW-1:0] y_q, y_d;
  logic [3:0]    flags_q, flags_d;
  logic          grant;
  logic          any_valid;

  assign any_valid = req0_valid | req1_valid;

  // Only the valids and the pointer feed the grant, so ready never depends on rsp_ready.
  always_comb begin
`ifdef ALU_ARB_FIXED_PRI_EN
    grant = ~req0_valid;
`else
    if (req0_valid && req1_valid) grant = ~last_q;
    else                          grant = ~req0_valid;
`endif
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    id_d       = id_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    y_d        = y_q;
    flags_d    = flags_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!RESET && any_valid) begin
          req0_ready = ~grant;
          req1_ready = grant;
          state_d    = EXEC;
          last_d     = grant;
          id_d       = grant;
          a_d        = grant ? req1_a  : req0_a;
          b_d        = grant ? req1_b  : req0_b;
          op_d       = grant ? req1_op : req0_op;
        end
      end
      EXEC: begin
        y_d     = alu_y;
        flags_d = {alu_c, alu_v, alu_n, alu_z};
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      y_q     <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      y_q     <= y_d;
      flags_q <= flags_d;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign rsp_id    = id_q;
  assign rsp_y     = y_q;
  assign rsp_flags = flags_q;

endmodule
